// File: rtl/dma_w_buf.sv
// dma_w_buf: first-word-fall-through write-request buffer, ext_addrgen -> axi_dma_w.
// Latency 1 from push to head; sustains 1 beat/cycle in each direction.
// Backpressure: s_ready = !full from registered state only; no push while full, even with a pop.
// Optional run marking (m_first tagging) is built when DMA_WBUF_RUN_EN is defined.
module dma_w_buf #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 30,
  parameter int DEPTH_LOG2 = 4,
  parameter int MAX_RUN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_first,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  // Reject configurations the run-marking counter and 4 KB check cannot handle.
  if (MAX_RUN < 1 || MAX_RUN > 256 || ADDR_W < 12) begin : g_bad_cfg
    $error("dma_w_buf: MAX_RUN must be 1..256 and ADDR_W at least 12");
  end

  // Occupancy and pointers; level counts the head register as well as the array.
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;

  // Backing array (not reset) and the registered head stage that drives m_*.
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [STRB_W-1:0] mem_wstrb [DEPTH];

  logic [ADDR_W-1:0] head_addr_q;
  logic [DATA_W-1:0] head_wdata_q;
  logic [STRB_W-1:0] head_wstrb_q;

  logic full, empty, push, pop;
  logic load_in;   // incoming beat goes straight into the head register
  logic load_mem;  // head refills from the array after a pop
  logic arr_wr;    // incoming beat is parked in the array

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign s_ready = ~full;
  assign m_valid = ~empty;
  assign level   = level_q;

  assign push = s_valid & ~full;
  assign pop  = m_valid & m_ready;

  // The array only ever holds entries behind the head, so at most DEPTH-1 of them.
  assign load_mem = pop & (level_q > LVL_ONE);
  assign load_in  = push & (empty | (pop & (level_q == LVL_ONE)));
  assign arr_wr   = push & ~load_in;

  assign m_addr  = head_addr_q;
  assign m_wdata = head_wdata_q;
  assign m_wstrb = head_wstrb_q;

  // Next-state for occupancy and pointers.
  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
    if (arr_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (load_mem) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Array write port; contents survive reset, the pointers make them invisible.
  always_ff @(posedge clk) begin
    if (arr_wr) begin
      mem_addr[wr_ptr_q]  <= s_addr;
      mem_wdata[wr_ptr_q] <= s_wdata;
      mem_wstrb[wr_ptr_q] <= s_wstrb;
    end
  end

`ifdef DMA_WBUF_RUN_EN
  localparam int BYTES = DATA_W / 8;
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic              have_prev_q, have_prev_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [ADDR_W-1:0] next_addr;
  logic              s_first;
  logic              mem_first [DEPTH];
  logic              head_first_q;

  // A new run starts on any gap, a full run, or a 4 KB page boundary.
  assign next_addr = prev_addr_q + ADDR_W'(BYTES);
  assign s_first   = ~have_prev_q
                   | (s_addr != next_addr)
                   | (run_cnt_q == RUN_W'(MAX_RUN))
                   | (s_addr[11:0] == 12'h000);

  // Run tracker follows the accepted push stream only.
  always_comb begin
    prev_addr_d = prev_addr_q;
    have_prev_d = have_prev_q;
    run_cnt_d   = run_cnt_q;
    if (push) begin
      prev_addr_d = s_addr;
      have_prev_d = 1'b1;
      run_cnt_d   = s_first ? RUN_W'(1) : run_cnt_q + RUN_W'(1);
    end
  end

  // Run tracker registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_addr_q <= '0;
      have_prev_q <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      prev_addr_q <= prev_addr_d;
      have_prev_q <= have_prev_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  // Stored first bit travels with its beat through the array.
  always_ff @(posedge clk) begin
    if (arr_wr) begin
      mem_first[wr_ptr_q] <= s_first;
    end
  end

  // Head first bit, refilled alongside the other head fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_first_q <= 1'b0;
    end else if (load_mem) begin
      head_first_q <= mem_first[rd_ptr_q];
    end else if (load_in) begin
      head_first_q <= s_first;
    end
  end

  // Gate with m_valid so a stale bit never shows on an empty buffer.
  assign m_first = head_first_q & m_valid;
`else
  // Without run marking every beat is its own burst.
  assign m_first = m_valid;
`endif

  // Head register: refill from the array, or take the incoming beat directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_addr_q  <= '0;
      head_wdata_q <= '0;
      head_wstrb_q <= '0;
    end else if (load_mem) begin
      head_addr_q  <= mem_addr[rd_ptr_q];
      head_wdata_q <= mem_wdata[rd_ptr_q];
      head_wstrb_q <= mem_wstrb[rd_ptr_q];
    end else if (load_in) begin
      head_addr_q  <= s_addr;
      head_wdata_q <= s_wdata;
      head_wstrb_q <= s_wstrb;
    end
  end

endmodule
